ssp_uart_rx: RTL and testbench

Parametrised UART receive channel for the next-generation SSP UART. It oversamples the RS-232 receive input, deframes words of configurable width with optional parity, and buffers them with per-word error tags in a show-ahead FIFO of configurable depth. The SSP register layer reads the FIFO output and sticky status. The block replaces the fixed 8-bit, fixed-depth receive path of the current SSP UART.

---
 rtl/ssp_uart_pkg.sv | 26 ++
 rtl/ssp_uart_fifo.sv | 55 +++++
 rtl/ssp_uart_rx.sv | 176 +++++++++++++++++
 tb/tb_ssp_uart_rx.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ssp_uart_pkg.sv
// Shared SSP UART definitions: rx FSM states, parity modes, register map.
// Parity support in the receiver is built only when SSP_UART_RX_PARITY_EN is defined.
package ssp_uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE  = 3'd0,
        RX_START = 3'd1,
        RX_DATA  = 3'd2,
        RX_PAR   = 3'd3,
        RX_STOP  = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2,
        PAR_RSVD = 2'd3
    } par_mode_e;

    localparam logic [2:0] UCR = 3'd0;
    localparam logic [2:0] USR = 3'd1;
    localparam logic [2:0] TDR = 3'd2;
    localparam logic [2:0] RDR = 3'd3;
    localparam logic [2:0] SPR = 3'd4;

endpackage

// File: rtl/ssp_uart_fifo.sv
// Show-ahead FIFO with occupancy count; shared by the rx and tx channels.
// Head output reads as zero while empty.
module ssp_uart_fifo
    import ssp_uart_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ssp_uart_rx.sv
// SSP UART receive channel: oversampled deframer feeding a tagged rx FIFO.
// Define SSP_UART_RX_PARITY_EN to build the parity bit state and PE tag.
module ssp_uart_rx
    import ssp_uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                          Clk,
    input  logic                          xRst,
    input  logic                          Rx_En,
    input  logic [15:0]                   BaudDiv,
    input  logic [1:0]                    ParMode,
    input  logic                          RxD,
    input  logic                          Rd,
    input  logic                          ClrFifo,
    input  logic                          ClrErr,
    output logic [DATA_W-1:0]             RDat,
    output logic                          RPE,
    output logic                          RFE,
    output logic                          Empty,
    output logic                          Full,
    output logic [$clog2(FIFO_DEPTH):0]   Count,
    output logic                          OVR,
    output logic                          BRK
);

    localparam int PW = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] PH_S0  = PW'(OVERSAMPLE/2 - 1);
    localparam logic [PW-1:0] PH_S1  = PW'(OVERSAMPLE/2);
    localparam logic [PW-1:0] PH_S2  = PW'(OVERSAMPLE/2 + 1);
    localparam logic [PW-1:0] PH_END = PW'(OVERSAMPLE - 1);

    logic              sync1, sync2, rx_q, fall;
    logic [15:0]       baud_cnt;
    logic              tick, mid, vote;
    rx_state_e         state;
    logic [PW-1:0]     phase;
    logic [3:0]        bit_cnt;
    logic              s0, s1;
    logic [DATA_W-1:0] shreg;
    logic              pe, fe, par_bit, push;
    logic              brk_set, ovr_set;
    logic              par_on, odd;
    logic [DATA_W+1:0] head;

`ifdef SSP_UART_RX_PARITY_EN
    assign par_on = (ParMode == PAR_ODD) || (ParMode == PAR_EVEN);
    assign odd    = (ParMode == PAR_ODD);
`else
    logic unused_par;
    assign par_on     = 1'b0;
    assign odd        = 1'b0;
    assign unused_par = ^ParMode;
`endif

    always_ff @(posedge Clk or negedge xRst) begin
        if (!xRst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            sync1 <= RxD;
            sync2 <= sync1;
            rx_q  <= sync2;
        end
    end

    assign fall = rx_q & ~sync2;

    always_ff @(posedge Clk or negedge xRst) begin
        if (!xRst)     baud_cnt <= '0;
        else if (tick) baud_cnt <= BaudDiv;
        else           baud_cnt <= baud_cnt - 1'b1;
    end

    assign tick = (baud_cnt == '0);
    assign mid  = tick && (phase == PH_S2);
    assign vote = (s0 & s1) | (s0 & sync2) | (s1 & sync2);

    always_ff @(posedge Clk or negedge xRst) begin
        if (!xRst) begin
            state   <= RX_IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            s0      <= 1'b1;
            s1      <= 1'b1;
            shreg   <= '0;
            pe      <= 1'b0;
            fe      <= 1'b0;
            par_bit <= 1'b0;
            push    <= 1'b0;
        end else begin
            push <= 1'b0;
            if (tick) begin
                phase <= (phase == PH_END) ? '0 : phase + 1'b1;
                if (phase == PH_S0) s0 <= sync2;
                if (phase == PH_S1) s1 <= sync2;
            end
            if (!Rx_En) begin
                state <= RX_IDLE;
            end else begin
                unique case (state)
                    RX_IDLE: if (fall) begin
                        state   <= RX_START;
                        phase   <= '0;
                        bit_cnt <= '0;
                        pe      <= 1'b0;
                        fe      <= 1'b0;
                        par_bit <= 1'b0;
                    end
                    RX_START: if (mid) begin
                        state <= vote ? RX_IDLE : RX_DATA;
                    end
                    RX_DATA: if (mid) begin
                        shreg   <= {vote, shreg[DATA_W-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 4'(DATA_W - 1))
                            state <= par_on ? RX_PAR : RX_STOP;
                    end
`ifdef SSP_UART_RX_PARITY_EN
                    RX_PAR: if (mid) begin
                        par_bit <= vote;
                        pe      <= (^{shreg, vote}) ^ odd;
                        state   <= RX_STOP;
                    end
`endif
                    RX_STOP: if (mid) begin
                        fe    <= ~vote;
                        push  <= 1'b1;
                        state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

    // A break is a framing error on an all-zero word, parity bit included.
    assign brk_set = push & fe & (shreg == '0) & ~par_bit;
    assign ovr_set = push & Full & ~Rd & ~ClrFifo;

    always_ff @(posedge Clk or negedge xRst) begin
        if (!xRst) begin
            OVR <= 1'b0;
            BRK <= 1'b0;
        end else begin
            if (ovr_set)     OVR <= 1'b1;
            else if (ClrErr) OVR <= 1'b0;
            if (brk_set)     BRK <= 1'b1;
            else if (ClrErr) BRK <= 1'b0;
        end
    end

    ssp_uart_fifo #(
        .WIDTH (DATA_W + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (xRst),
        .clr   (ClrFifo),
        .push  (push),
        .pop   (Rd),
        .din   ({pe, fe, shreg}),
        .dout  (head),
        .empty (Empty),
        .full  (Full),
        .count (Count)
    );

    assign RDat = head[DATA_W-1:0];
    assign RFE  = head[DATA_W];
    assign RPE  = head[DATA_W+1];

endmodule

// File: tb/tb_ssp_uart_rx.sv
// Directed bench for ssp_uart_rx: serial frames in, scoreboard of
// expected {PE, FE, data} entries checked as the FIFO is drained.
module tb_ssp_uart_rx;

    localparam int DW  = 8;
    localparam int FD  = 16;
    localparam int BIT = 64;

    logic          Clk = 1'b0;
    logic          xRst, Rx_En, RxD, Rd, ClrFifo, ClrErr;
    logic [15:0]   BaudDiv;
    logic [1:0]    ParMode;
    logic [DW-1:0] RDat;
    logic          RPE, RFE, Empty, Full, OVR, BRK;
    logic [4:0]    Count;

    int compared   = 0;
    int mismatched = 0;
    logic [DW+1:0] exp_q[$];

    always #5 Clk = ~Clk;

    ssp_uart_rx #(
        .DATA_W     (DW),
        .FIFO_DEPTH (FD),
        .OVERSAMPLE (16)
    ) dut (
        .Clk     (Clk),
        .xRst    (xRst),
        .Rx_En   (Rx_En),
        .BaudDiv (BaudDiv),
        .ParMode (ParMode),
        .RxD     (RxD),
        .Rd      (Rd),
        .ClrFifo (ClrFifo),
        .ClrErr  (ClrErr),
        .RDat    (RDat),
        .RPE     (RPE),
        .RFE     (RFE),
        .Empty   (Empty),
        .Full    (Full),
        .Count   (Count),
        .OVR     (OVR),
        .BRK     (BRK)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        RxD = b;
        repeat (BIT) @(posedge Clk);
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input bit par_on,
                              input logic p, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
        if (par_on) send_bit(p);
        send_bit(stop);
    endtask

    task automatic pop_check(input string tag);
        logic [DW+1:0] e;
        @(negedge Clk);
        check({tag, "_avail"}, Empty, 0);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(tag, {RPE, RFE, RDat}, e);
        end else begin
            compared++;
            mismatched++;
            $error("FAIL %s: observed entry expected none (scoreboard empty)", tag);
        end
        Rd = 1'b1;
        @(negedge Clk);
        Rd = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rdat"},  RDat,  0);
        check({tag, "_rpe"},   RPE,   0);
        check({tag, "_rfe"},   RFE,   0);
        check({tag, "_empty"}, Empty, 1);
        check({tag, "_full"},  Full,  0);
        check({tag, "_count"}, Count, 0);
        check({tag, "_ovr"},   OVR,   0);
        check({tag, "_brk"},   BRK,   0);
    endtask

    initial begin
        logic [DW-1:0] d;
        xRst = 1'b0; Rx_En = 1'b1; RxD = 1'b1; Rd = 1'b0;
        ClrFifo = 1'b0; ClrErr = 1'b0; BaudDiv = 16'd3; ParMode = 2'd0;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        xRst = 1'b1;
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        check_reset_vals("reset");

        // 0xA5 8N1 with a push-timing window inside the stop bit
        exp_q.push_back({2'b00, 8'hA5});
        send_bit(1'b0);
        d = 8'hA5;
        for (int i = 0; i < DW; i++) send_bit(d[i]);
        RxD = 1'b1;
        repeat (30) @(posedge Clk);
        @(negedge Clk);
        check("a5_before_push", Empty, 1);
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        check("a5_after_push", Empty, 0);
        check("a5_count", Count, 1);
        repeat (BIT) @(posedge Clk);
        pop_check("a5_head");
        check("a5_drained", Empty, 1);

`ifdef SSP_UART_RX_PARITY_EN
        ParMode = 2'd2;
        exp_q.push_back({2'b10, 8'h0F});
        send_frame(8'h0F, 1'b1, 1'b1, 1'b1);
        exp_q.push_back({2'b00, 8'h0F});
        send_frame(8'h0F, 1'b1, 1'b0, 1'b1);
        @(negedge Clk);
        check("par_count", Count, 2);
        pop_check("par_bad");
        pop_check("par_good");
        ParMode = 2'd0;
`else
        ParMode = 2'd2;
        exp_q.push_back({2'b00, 8'h0F});
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        pop_check("par_ignored");
        ParMode = 2'd0;
`endif

        // 17 frames without reads: last one overruns
        for (int i = 0; i < 17; i++) begin
            d = 8'(8'hF1 - i * 15);
            if (i < FD) exp_q.push_back({2'b00, d});
            send_frame(d, 1'b0, 1'b0, 1'b1);
        end
        @(negedge Clk);
        check("ovr_count", Count, 16);
        check("ovr_full", Full, 1);
        check("ovr_flag", OVR, 1);
        check("ovr_head", RDat, 8'hF1);
        ClrErr = 1'b1;
        @(negedge Clk);
        ClrErr = 1'b0;
        @(negedge Clk);
        check("ovr_cleared", OVR, 0);
        for (int i = 0; i < FD; i++) pop_check("ovr_drain");
        check("drain_empty", Empty, 1);
        Rd = 1'b1;
        @(negedge Clk);
        Rd = 1'b0;
        @(negedge Clk);
        check("rd_empty_count", Count, 0);

        // flush
        exp_q.push_back({2'b00, 8'h12});
        send_frame(8'h12, 1'b0, 1'b0, 1'b1);
        exp_q.push_back({2'b00, 8'h34});
        send_frame(8'h34, 1'b0, 1'b0, 1'b1);
        @(negedge Clk);
        check("clr_pre_count", Count, 2);
        ClrFifo = 1'b1;
        @(negedge Clk);
        ClrFifo = 1'b0;
        exp_q.delete();
        check("clr_count", Count, 0);
        check("clr_empty", Empty, 1);

        // break: 12 bit times low
        exp_q.push_back({2'b01, 8'h00});
        RxD = 1'b0;
        repeat (12 * BIT) @(posedge Clk);
        RxD = 1'b1;
        repeat (2 * BIT) @(posedge Clk);
        @(negedge Clk);
        check("brk_count", Count, 1);
        check("brk_flag", BRK, 1);
        pop_check("brk_word");
        ClrErr = 1'b1;
        @(negedge Clk);
        ClrErr = 1'b0;
        @(negedge Clk);
        check("brk_cleared", BRK, 0);

        // short glitch, then a clean frame
        RxD = 1'b0;
        repeat (20) @(posedge Clk);
        RxD = 1'b1;
        repeat (3 * BIT) @(posedge Clk);
        @(negedge Clk);
        check("glitch_count", Count, 0);
        exp_q.push_back({2'b00, 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        pop_check("post_glitch");

        // receiver disabled mid-frame
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        Rx_En = 1'b0;
        for (int i = 0; i < 6; i++) send_bit(i[0]);
        send_bit(1'b1);
        repeat (BIT) @(posedge Clk);
        Rx_En = 1'b1;
        repeat (2 * BIT) @(posedge Clk);
        @(negedge Clk);
        check("rxen_count", Count, 0);

        // reset mid-frame with a word already buffered
        send_frame(8'h99, 1'b0, 1'b0, 1'b1);
        @(negedge Clk);
        check("rst_pre_count", Count, 1);
        send_bit(1'b0);
        send_bit(1'b1);
        RxD = 1'b0;
        repeat (10) @(posedge Clk);
        @(negedge Clk);
        xRst = 1'b0;
        RxD  = 1'b1;
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        xRst = 1'b1;
        @(negedge Clk);
        check_reset_vals("midrst");
        repeat (12 * BIT) @(posedge Clk);
        @(negedge Clk);
        check("midrst_no_push", Count, 0);
        check("scoreboard_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
